sprite_anim_seq: RTL and testbench
==================================

Name: sprite_anim_seq

Overview:
- Per-fighter animation sequencer that drives the sprite ROM/palette draw path.
- Takes action requests from game logic and steps frame indices on vertical-sync boundaries.
- Outputs the ROM base address of the current sprite frame, which the sprite draw block adds to its in-sprite pixel offset.
- One instance per player; frames change only between video frames, so a sprite never tears mid-scan.

Parameters:
- SPRITE_DIM, 64, sprite edge in pixels; frame size = SPRITE_DIM*SPRITE_DIM words
- FRAMES, 4, frames per action (power of two)
- HOLD_TICKS, 6, vsync ticks each frame is displayed
- RECOVER_TICKS, 8, vsync ticks the last frame of a one-shot is held
- ADDR_W, 17, ROM address width (must hold 6*FRAMES*SPRITE_DIM^2)

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- vsync_tick  in  1  one-cycle pulse at the start of each video frame
- req_valid  in  1  action request valid
- req_action  in  3  0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 DESPMOVE, 5 HIT; 6–7 reserved
- req_ready  out  1  sequencer can accept a request
- hit_pulse  in  1  fighter was struck; preempts everything
- action  out  3  action currently displayed
- frame_idx  out  log2(FRAMES)  frame currently displayed
- rom_base  out  ADDR_W  (action*FRAMES+frame_idx)*SPRITE_DIM^2, registered
- busy  out  1  one-shot or recovery in progress
- done  out  1  one-cycle pulse when a one-shot finishes

Behaviour:
- Reset, asynchronous: state=S_LOOP, action=IDLE, frame_idx=0, hold_cnt=0, rec_cnt=0, pending empty, pending_hit=0, rom_base=0, busy=0, done=0, req_ready=1 after reset release. A reset mid-animation aborts it immediately; no done pulse is produced.
- Action classes: IDLE and WALK are loop actions; PUNCH, KICK, DESPMOVE and HIT are one-shots.
- States:
  - S_LOOP: plays a loop action.
  - S_ONESHOT: plays a one-shot.
  - S_RECOVER: holds the last frame of a one-shot.
- req_ready = (state==S_LOOP) && !pending_full && !pending_hit. It never depends on req_valid.
- Acceptance (req_valid && req_ready at a posedge):
  - Codes 0–5 are latched into pending. Reserved codes 6–7 are consumed and discarded.
  - Acceptance and vsync_tick in the same cycle: the request is latched, then applied at the following vsync_tick.
- hit_pulse in any state sets pending_hit. It is sticky until the next vsync_tick.
- On vsync_tick, priority order:
  1. pending_hit: action=HIT, frame_idx=0, hold_cnt=0, state=S_ONESHOT. Pending is cleared and that request is dropped. pending_hit=0.
  2. pending full, pending==current loop action: no restart; frame and hold counts continue. Pending is cleared.
  3. Other pending: action=pending, frame_idx=0, hold_cnt=0, state by class. Pending is cleared.
  4. No pending: advance. hold_cnt++. When hold_cnt==HOLD_TICKS-1: hold_cnt=0, then
     - S_LOOP: frame_idx wraps modulo FRAMES.
     - S_ONESHOT, frame_idx==FRAMES-1: state=S_RECOVER, rec_cnt=0.
     - S_ONESHOT otherwise: frame_idx++.
  5. S_RECOVER: rec_cnt++. When rec_cnt==RECOVER_TICKS-1: action=IDLE, frame_idx=0, state=S_LOOP, done=1 for one cycle.
- A HIT arriving during a one-shot or recovery aborts it and gives no done pulse for the aborted action. HIT during HIT restarts HIT from frame 0.
- busy = (state!=S_LOOP), registered with the state.
- rom_base is recomputed each cycle from the registered action/frame_idx. It lags them by one vga_clk, so it is stable well before active video.
- Arithmetic: the product uses constant shifts (FRAMES and SPRITE_DIM are powers of two). No overflow at the ADDR_W default.
- No frame change ever occurs between vsync_ticks.

Decomposition:
- Package sprite_anim_pkg holds:
  - action_t enum (IDLE..HIT)
  - anim_state_t enum (S_LOOP, S_ONESHOT, S_RECOVER)
  - function is_oneshot(action_t)
  - default SPRITE_DIM/FRAMES constants
- One sub-module, anim_tick_counter: hold/recover tick counter with load, enable and terminal-count output. It is instantiated twice.
- Address generation stays inline.

Test Plan:
- Reset, then 30 vsync_ticks with no requests -> action=0. frame_idx steps 0,1,2,3,0 every 6 ticks. rom_base = frame_idx*4096.
- In IDLE, request PUNCH (2) -> req_ready drops for the rest of the one-shot. At the next tick action=2, frame 0, rom_base=32768, busy=1. After 24 ticks the sequencer enters recover on frame 3. 8 ticks later: action=0, done pulses one cycle, busy=0.
- WALK looping at frame 2, request WALK again -> no restart; frame_idx continues 2→3 on schedule.
- DESPMOVE at frame 2, then hit_pulse -> next tick action=5, frame 0, rom_base=81920. No done pulse for DESPMOVE.
- hit_pulse and an accepted KICK in the same cycle -> at the next tick HIT plays and KICK is never shown.
- Assert reset_n low mid-KICK, between ticks -> outputs are at reset values immediately (asynchronous). After release, req_ready=1 and action=0.

Source files
------------

// File: rtl/sprite_anim_pkg.sv
// Shared types and defaults for the per-fighter sprite animation sequencer.
package sprite_anim_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WALK     = 3'd1,
      PUNCH    = 3'd2,
      KICK     = 3'd3,
      DESPMOVE = 3'd4,
      HIT      = 3'd5
   } action_t;

   typedef enum logic [1:0] {
      S_LOOP    = 2'd0,
      S_ONESHOT = 2'd1,
      S_RECOVER = 2'd2
   } anim_state_t;

   localparam int DEF_SPRITE_DIM = 64;
   localparam int DEF_FRAMES     = 4;

   // IDLE and WALK repeat forever; everything else plays once then recovers.
   function automatic logic is_oneshot(action_t a);
      return (a == PUNCH) || (a == KICK) || (a == DESPMOVE) || (a == HIT);
   endfunction

endpackage

// File: rtl/anim_tick_counter.sv
// Vsync tick counter: clears on load, counts on enable, wraps to zero after TERM.
module anim_tick_counter #(
   parameter int W    = 3,
   parameter int TERM = 5
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   assign tc_o  = (cnt_q == W'(TERM));
   assign cnt_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/sprite_anim_seq.sv
// Per-fighter animation sequencer: latches action requests, steps frames only on
// vsync ticks and produces the ROM base address of the displayed sprite frame.
module sprite_anim_seq
   import sprite_anim_pkg::*;
#(
   parameter int SPRITE_DIM    = DEF_SPRITE_DIM,
   parameter int FRAMES        = DEF_FRAMES,
   parameter int HOLD_TICKS    = 6,
   parameter int RECOVER_TICKS = 8,
   parameter int ADDR_W        = 17
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic                      vsync_tick,
   input  logic                      req_valid,
   input  logic [2:0]                req_action,
   output logic                      req_ready,
   input  logic                      hit_pulse,
   output logic [2:0]                action,
   output logic [$clog2(FRAMES)-1:0] frame_idx,
   output logic [ADDR_W-1:0]         rom_base,
   output logic                      busy,
   output logic                      done
);

   localparam int FW    = $clog2(FRAMES);
   localparam int HW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int RW    = (RECOVER_TICKS > 1) ? $clog2(RECOVER_TICKS) : 1;
   localparam int SHIFT = $clog2(SPRITE_DIM * SPRITE_DIM);

   anim_state_t       state_q;
   action_t           action_q;
   logic [FW-1:0]     frame_q;
   logic              pend_valid_q;
   action_t           pend_act_q;
   logic              pend_hit_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] rom_base_q;

   logic          accept, restart, advance;
   logic          hold_en, rec_en, rec_load, last_frame;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rec_cnt;
   logic          hold_tc, rec_tc;

   assign req_ready = (state_q == S_LOOP) && !pend_valid_q && !pend_hit_q;
   assign accept    = req_valid && req_ready;

   // Re-requesting the loop already on screen is not a restart: it just advances.
   assign restart    = vsync_tick && (pend_hit_q ||
                       (pend_valid_q && !(state_q == S_LOOP && pend_act_q == action_q)));
   assign advance    = vsync_tick && !restart;
   assign last_frame = (frame_q == FW'(FRAMES - 1));
   assign hold_en    = advance && (state_q != S_RECOVER);
   assign rec_en     = advance && (state_q == S_RECOVER);
   assign rec_load   = restart || (hold_en && state_q == S_ONESHOT && hold_tc && last_frame);

   anim_tick_counter #(.W(HW), .TERM(HOLD_TICKS - 1)) u_hold_cnt (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .load_i (restart),
      .en_i   (hold_en),
      .cnt_o  (hold_cnt),
      .tc_o   (hold_tc)
   );

   anim_tick_counter #(.W(RW), .TERM(RECOVER_TICKS - 1)) u_rec_cnt (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .load_i (rec_load),
      .en_i   (rec_en),
      .cnt_o  (rec_cnt),
      .tc_o   (rec_tc)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_LOOP;
         action_q     <= IDLE;
         frame_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_act_q   <= IDLE;
         pend_hit_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rom_base_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (vsync_tick) pend_valid_q <= 1'b0;
         // A request taken on a tick cycle survives that tick and applies at the next.
         if (accept && req_action <= 3'd5) begin
            pend_valid_q <= 1'b1;
            pend_act_q   <= action_t'(req_action);
         end
         if (vsync_tick) pend_hit_q <= 1'b0;
         if (hit_pulse)  pend_hit_q <= 1'b1;

         if (restart) begin
            action_q <= pend_hit_q ? HIT : pend_act_q;
            frame_q  <= '0;
            if (pend_hit_q || is_oneshot(pend_act_q)) begin
               state_q <= S_ONESHOT;
               busy_q  <= 1'b1;
            end else begin
               state_q <= S_LOOP;
               busy_q  <= 1'b0;
            end
         end else if (advance) begin
            case (state_q)
               S_LOOP: begin
                  if (hold_tc) frame_q <= frame_q + 1'b1;
               end
               S_ONESHOT: begin
                  if (hold_tc) begin
                     if (last_frame) state_q <= S_RECOVER;
                     else            frame_q <= frame_q + 1'b1;
                  end
               end
               S_RECOVER: begin
                  if (rec_tc) begin
                     action_q <= IDLE;
                     frame_q  <= '0;
                     state_q  <= S_LOOP;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end
               default: state_q <= S_LOOP;
            endcase
         end

         rom_base_q <= ADDR_W'({action_q, frame_q}) << SHIFT;
      end
   end

   assign action    = action_q;
   assign frame_idx = frame_q;
   assign rom_base  = rom_base_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq: a behavioural model predicts every vsync
// step; predictions queue up and are compared when the DUT settles.
module tb_sprite_anim_seq;

   localparam int HT = 6;
   localparam int RT = 8;
   localparam int W  = 25;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vsync_tick = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_action = 3'd0;
   logic        hit_pulse = 1'b0;
   logic        req_ready;
   logic [2:0]  action;
   logic [1:0]  frame_idx;
   logic [16:0] rom_base;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_seen = 0;
   int done_at_mark;

   logic [W-1:0] exp_q[$];

   int m_state, m_act, m_frame, m_hold, m_rec, m_pv, m_pend, m_phit, m_done;

   sprite_anim_seq dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .vsync_tick (vsync_tick),
      .req_valid  (req_valid),
      .req_action (req_action),
      .req_ready  (req_ready),
      .hit_pulse  (hit_pulse),
      .action     (action),
      .frame_idx  (frame_idx),
      .rom_base   (rom_base),
      .busy       (busy),
      .done       (done)
   );

   always #5 vga_clk = ~vga_clk;

   always @(negedge vga_clk) if (done === 1'b1) done_seen++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input int a, input int f, input int b,
                                         input int d, input int r);
      int rb;
      rb = (a * 4 + f) * 4096;
      return {3'(a), 2'(f), 1'(b), 1'(d), 1'(r), 17'(rb)};
   endfunction

   function automatic int m_ready();
      return (m_state == 0 && m_pv == 0 && m_phit == 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_act = 0; m_frame = 0; m_hold = 0; m_rec = 0;
      m_pv = 0; m_pend = 0; m_phit = 0; m_done = 0;
   endtask

   task automatic model_tick();
      m_done = 0;
      if (m_phit != 0) begin
         m_act = 5; m_frame = 0; m_hold = 0; m_state = 1; m_pv = 0; m_phit = 0;
      end else if (m_pv != 0 && !(m_state == 0 && m_pend == m_act)) begin
         m_act = m_pend; m_frame = 0; m_hold = 0; m_pv = 0;
         m_state = (m_pend >= 2) ? 1 : 0;
      end else begin
         m_pv = 0;
         if (m_state == 2) begin
            if (m_rec == RT - 1) begin
               m_act = 0; m_frame = 0; m_state = 0; m_rec = 0; m_done = 1;
            end else begin
               m_rec++;
            end
         end else if (m_hold == HT - 1) begin
            m_hold = 0;
            if (m_state == 0)       m_frame = (m_frame + 1) % 4;
            else if (m_frame == 3)  begin m_state = 2; m_rec = 0; end
            else                    m_frame++;
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic tick();
      logic [W-1:0] obs, exp;
      @(negedge vga_clk);
      vsync_tick = 1'b1;
      model_tick();
      exp_q.push_back(pack(m_act, m_frame, (m_state != 0) ? 1 : 0, m_done, m_ready()));
      @(negedge vga_clk);
      vsync_tick = 1'b0;
      obs[W-1:17] = {action, frame_idx, busy, done, req_ready};
      @(negedge vga_clk);
      obs[16:0] = rom_base;
      exp = exp_q.pop_front();
      check("tick", 32'(obs), 32'(exp));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic request(input int a, input bit with_hit);
      @(negedge vga_clk);
      check("req_ready", 32'(req_ready), 32'(m_ready()));
      if (m_ready() != 0 && a <= 5) begin
         m_pv = 1; m_pend = a;
      end
      if (with_hit) m_phit = 1;
      req_valid  = 1'b1;
      req_action = 3'(a);
      hit_pulse  = with_hit;
      @(negedge vga_clk);
      req_valid = 1'b0;
      hit_pulse = 1'b0;
      check("no_change_between_ticks", 32'({action, frame_idx}), 32'({3'(m_act), 2'(m_frame)}));
   endtask

   task automatic hit();
      @(negedge vga_clk);
      hit_pulse = 1'b1;
      m_phit = 1;
      @(negedge vga_clk);
      hit_pulse = 1'b0;
      check("hit_ready_low", 32'(req_ready), 32'd0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge vga_clk);
      check("rst_action", 32'(action), 32'd0);
      check("rst_frame", 32'(frame_idx), 32'd0);
      check("rst_rom_base", 32'(rom_base), 32'd0);
      check("rst_busy_done", 32'({busy, done}), 32'd0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      check("rst_ready", 32'(req_ready), 32'd1);

      // Idle loop: frame steps every six ticks and wraps after frame 3.
      ticks(30);
      check("idle_frame_after_30", 32'(frame_idx), 32'd1);

      // PUNCH one-shot through recovery back to IDLE.
      done_at_mark = done_seen;
      request(2, 1'b0);
      check("punch_ready_low", 32'(req_ready), 32'd0);
      tick();
      check("punch_rom_base", 32'(rom_base), 32'd32768);
      ticks(24);
      check("punch_recover_frame", 32'({action, frame_idx, busy}), 32'({3'd2, 2'd3, 1'b1}));
      ticks(8);
      check("punch_done_once", 32'(done_seen - done_at_mark), 32'd1);

      // WALK re-request does not restart the loop.
      request(1, 1'b0);
      ticks(13);
      ticks(3);
      request(1, 1'b0);
      ticks(3);
      check("walk_frame_continues", 32'(frame_idx), 32'd3);

      // Reserved code is consumed without effect.
      request(6, 1'b0);
      check("reserved_ready", 32'(req_ready), 32'd1);
      ticks(2);

      // HIT aborts DESPMOVE with no done for the aborted move.
      request(4, 1'b0);
      ticks(13);
      done_at_mark = done_seen;
      hit();
      tick();
      check("hit_rom_base", 32'(rom_base), 32'd81920);
      check("despmove_no_done", 32'(done_seen - done_at_mark), 32'd0);
      ticks(7);
      hit();
      tick();
      check("hit_restart_frame", 32'(frame_idx), 32'd0);
      ticks(32);
      check("hit_done_once", 32'(done_seen - done_at_mark), 32'd1);

      // Hit and KICK accepted together: HIT wins, KICK never shows.
      request(3, 1'b1);
      tick();
      check("hit_beats_kick", 32'(action), 32'd5);
      ticks(32);

      // Asynchronous reset in the middle of a KICK.
      request(3, 1'b0);
      ticks(8);
      done_at_mark = done_seen;
      @(negedge vga_clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_outputs", 32'({action, frame_idx, busy, done}), 32'd0);
      check("mid_rst_rom_base", 32'(rom_base), 32'd0);
      model_reset();
      @(negedge vga_clk);
      reset_n = 1'b1;
      @(negedge vga_clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_action", 32'(action), 32'd0);
      ticks(7);
      check("rst_no_done", 32'(done_seen - done_at_mark), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
